// File: rtl/nvram_io.sv
// rtl/nvram_io.sv - NVRAM save/restore bridge between data_io transfers and the paused game RAM
module nvram_io #(
   parameter logic [7:0]  INDEX = 8'd4,
   parameter int          AW    = 8,
   parameter logic [15:0] BASE  = 16'h0000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_upload,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [7:0]  ioctl_din,
   output logic        pause_req,
   input  logic        pause_ack,
   output logic [15:0] ram_addr,
   input  logic [7:0]  ram_q,
   output logic [7:0]  ram_d,
   output logic        ram_we,
   output logic        busy,
   output logic        overflow
);

   typedef enum logic [2:0] {IDLE, REQ, UPLOAD, DOWNLOAD, DRAIN} state_t;

   state_t        state, state_next;
   logic          is_dl;
   logic          idx_hit, start, xfer_flag, addr_in_range;
   logic [AW-1:0] fifo_off [4];
   logic [7:0]    fifo_dat [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    count;
   logic          fifo_empty, fifo_full;
   logic          push_req, push_ok, pop;
   logic          up_valid_q;

   assign idx_hit       = (ioctl_index == INDEX);
   assign start         = idx_hit && (ioctl_download || ioctl_upload);
   assign xfer_flag     = is_dl ? ioctl_download : ioctl_upload;
   assign addr_in_range = ~|ioctl_addr[24:AW];
   assign fifo_empty    = (count == 3'd0);
   assign fifo_full     = (count == 3'd4);

   // Download bytes are queued from REQ onward so nothing is lost while the CPU is still halting;
   // the RAM port is only touched once the CPU confirms the halt.
   assign push_req = ioctl_wr && idx_hit && addr_in_range && (state != IDLE) && (state != UPLOAD);
   assign pop      = !reset && pause_ack && !fifo_empty && ((state == DOWNLOAD) || (state == DRAIN));
   assign push_ok  = push_req && (!fifo_full || pop);

   // State register
   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode and RAM port / handshake outputs
   always_comb begin
      state_next = state;
      pause_req  = (state != IDLE);
      busy       = (state != IDLE);
      ram_we     = pop;
      ram_addr   = BASE;
      ram_d      = 8'h00;
      case (state)
         IDLE:     if (start) state_next = REQ;
         REQ: begin
            if (!xfer_flag)     state_next = (is_dl && !fifo_empty) ? DRAIN : IDLE;
            else if (pause_ack) state_next = is_dl ? DOWNLOAD : UPLOAD;
         end
         UPLOAD:   if (pause_ack && !ioctl_upload)   state_next = IDLE;
         DOWNLOAD: if (pause_ack && !ioctl_download) state_next = DRAIN;
         DRAIN:    if (pause_ack && fifo_empty)      state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      if (!reset) begin
         if (state == UPLOAD) begin
            ram_addr = BASE + 16'(ioctl_addr[AW-1:0]);
         end else if (pop) begin
            ram_addr = BASE + 16'(fifo_off[rd_ptr]);
            ram_d    = fifo_dat[rd_ptr];
         end
      end
   end

   // Latch the transfer direction when a selected transfer starts
   always_ff @(posedge clk_sys) begin
      if (reset)                        is_dl <= 1'b0;
      else if (state == IDLE && start)  is_dl <= ioctl_download;
   end

   // FIFO storage; contents need no reset because count gates every read
   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         fifo_off[wr_ptr] <= ioctl_addr[AW-1:0];
         fifo_dat[wr_ptr] <= ioctl_dout;
      end
   end

   // FIFO pointers and occupancy; push_ok/pop rules keep count within 0..4
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 2'd1;
         if (pop)     rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push_ok} - {2'b00, pop};
      end
   end

   // Sticky drop flag, cleared when the next selected download begins
   always_ff @(posedge clk_sys) begin
      if (reset)                                          overflow <= 1'b0;
      else if (state == IDLE && start && ioctl_download)  overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)             overflow <= 1'b1;
   end

   // Upload read pipeline: range flag follows the address so ram_q lines up one cycle later
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         up_valid_q <= 1'b0;
         ioctl_din  <= 8'hFF;
      end else begin
         up_valid_q <= (state == UPLOAD) && addr_in_range;
         ioctl_din  <= up_valid_q ? ram_q : 8'hFF;
      end
   end

endmodule

// File: doc/nvram_io.md
NVRAM_IO -- requirements
Module: nvram_io

Interface
REQ-001 SHALL have parameter INDEX, default 8'd4, the ioctl_index value that selects NVRAM transfers.
REQ-002 SHALL have parameter AW, default 8, the NVRAM address width; depth is 2^AW bytes.
REQ-003 SHALL have parameter BASE, default 16'h0000, added to the transfer offset to form ram_addr.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_download  in  1  data_io download active.
REQ-007 ioctl_upload  in  1  data_io upload active.
REQ-008 ioctl_index  in  8  transfer index.
REQ-009 ioctl_wr  in  1  one-cycle download byte strobe.
REQ-010 ioctl_addr  in  25  byte offset of the current transfer.
REQ-011 ioctl_dout  in  8  download byte.
REQ-012 ioctl_din  out  8  upload byte returned to data_io.
REQ-013 pause_req  out  1  request to halt the game CPU.
REQ-014 pause_ack  in  1  CPU halted, RAM port owned by this block.
REQ-015 ram_addr  out  16  game RAM address.
REQ-016 ram_q  in  8  game RAM read data, valid 1 cycle after ram_addr.
REQ-017 ram_d  out  8  game RAM write data.
REQ-018 ram_we  out  1  game RAM write strobe.
REQ-019 busy  out  1  transfer in progress.
REQ-020 overflow  out  1  sticky: a download byte was dropped.

Function
REQ-021 A transfer is selected when ioctl_index==INDEX and ioctl_download or ioctl_upload is high; other indices are ignored entirely.
REQ-022 The FSM SHALL use states IDLE, REQ, UPLOAD, DOWNLOAD and DRAIN.
REQ-023 IDLE->REQ on a selected transfer start; pause_req and busy SHALL be high in every state except IDLE.
REQ-024 REQ->UPLOAD or REQ->DOWNLOAD on the first cycle pause_ack is high, according to the transfer type.
REQ-025 UPLOAD: ram_addr = BASE + ioctl_addr[AW-1:0] each cycle.
  - ioctl_din SHALL be ram_q registered, so it is valid 2 cycles after ioctl_addr changes.
  - Offsets >= 2^AW SHALL return 8'hFF.
REQ-026 DOWNLOAD path: every ioctl_wr with offset < 2^AW SHALL push {offset, data} into a 4-entry FIFO, in every state except IDLE.
  - Bytes pushed during REQ are held until pause_ack is seen.
  - Writes with offset >= 2^AW SHALL be discarded without setting overflow.
REQ-027 When pause_ack is high and the FIFO is not empty, one entry per cycle SHALL be popped to ram_addr/ram_d with ram_we high for exactly 1 cycle.
REQ-028 A push to a full FIFO SHALL drop the byte and set overflow, unless a pop occurs in the same cycle; a simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-029 DOWNLOAD->DRAIN when ioctl_download falls; DRAIN->IDLE once the FIFO is empty.
REQ-030 UPLOAD->IDLE when ioctl_upload falls.
REQ-031 Returning to IDLE SHALL drop pause_req on that transition cycle.
REQ-032 ram_we SHALL never assert while pause_ack is low.
  - If pause_ack falls mid-transfer, popping stops until pause_ack returns.
  - The state is unchanged while pause_ack is low.
REQ-033 If the transfer flag falls while in REQ, the FSM SHALL go to DRAIN for a download (FIFO non-empty) or to IDLE otherwise.
REQ-034 overflow SHALL clear only on reset or on the next selected download start.
REQ-035 FIFO pointers are 2 bits plus a count of 0..4; the count SHALL never wrap.

Reset
REQ-036 While reset is high:
  - state = IDLE and the FIFO is emptied.
  - pause_req, busy, ram_we and overflow are 0.
  - ioctl_din = 8'hFF, ram_addr = BASE, ram_d = 0.
REQ-037 A reset asserted mid-transfer SHALL abandon the transfer; un-drained FIFO bytes are lost and pause_req drops on the next cycle.

Verification
REQ-038 Upload: index 4, pause_ack 3 cycles after pause_req, ioctl_addr 0x10 with RAM[BASE+0x10]=0xA5 -> ioctl_din=0xA5 two cycles later; addr 0x100 -> 0xFF.
REQ-039 Download of 3 bytes 0x11,0x22,0x33 at offsets 0..2 with pause_ack low until after the last ioctl_wr -> three ram_we pulses at BASE+0..2 in order once pause_ack rises, then pause_req drops and overflow stays 0.
REQ-040 Download of 6 ioctl_wr with pause_ack held low -> first 4 bytes written after ack, overflow=1.
REQ-041 Index 0 download with ioctl_wr activity -> pause_req, ram_we and busy stay 0 throughout.
REQ-042 pause_ack dropped for 5 cycles with 2 FIFO entries pending -> no ram_we during the gap; both writes complete after ack returns.
REQ-043 reset pulsed in DOWNLOAD with 2 entries queued -> next cycle pause_req=0, busy=0, no further ram_we.
